// File: rtl/sr_cmd_conditioner.sv
// Purpose: synchronise, debounce and edge-detect raw set/clear lines, then arbitrate them into exclusive s/r pulses.
// Latency: raw line first sampled high at edge 1 -> s/r high after edge DEB_CYCLES+3, for exactly one cycle.
// Backpressure: none; rises seen while busy are discarded (dropped flag), simultaneous rises are refused (conflict flag).
module sr_cmd_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int HOLDOFF    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int CW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    // Bit 0 is the set channel, bit 1 the clear channel.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_d;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_rise;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_s;
    logic          r_r;
    logic          r_conflict;
    logic          r_dropped;
    logic          w_s_nxt;
    logic          w_r_nxt;
    logic          w_conflict_nxt;
    logic          w_dropped_nxt;

    assign w_raw  = {clr_raw, set_raw};
    assign w_rise = r_deb & ~r_deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            // A single agreeing sample restarts the count, so bounces shorter than DEB_CYCLES never flip the level.
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_s_nxt        = 1'b0;
        w_r_nxt        = 1'b0;
        w_conflict_nxt = 1'b0;
        w_dropped_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                case (w_rise)
                    2'b01: begin
                        w_state_nxt = PULSE;
                        w_s_nxt     = 1'b1;
                    end
                    2'b10: begin
                        w_state_nxt = PULSE;
                        w_r_nxt     = 1'b1;
                    end
                    2'b11: begin
                        w_conflict_nxt = 1'b1;
                        w_state_nxt    = (HOLDOFF == 0) ? IDLE : HOLD;
                        w_hold_nxt     = HOLD_LOAD;
                    end
                    default: ;
                endcase
            end
            PULSE: begin
                w_dropped_nxt = |w_rise;
                w_state_nxt   = (HOLDOFF == 0) ? IDLE : HOLD;
                w_hold_nxt    = HOLD_LOAD;
            end
            HOLD: begin
                // The HOLD->IDLE edge still rejects, so a new request needs a full idle cycle.
                w_dropped_nxt = |w_rise;
                if (r_hold == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_conflict <= w_conflict_nxt;
            r_dropped  <= w_dropped_nxt;
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign conflict = r_conflict;
    assign dropped  = r_dropped;
    assign busy     = (r_state != IDLE);

endmodule
